execute_cycle: RTL and testbench
================================

Name: execute_cycle

Overview:
- Execute stage of the 5-stage pipelined MIPS core.
- Consumes the ID/EX pipeline outputs: RD1E/RD2E, SignImmE, PCPlus4E, RsE/RtE/RdE and the control bits.
- Applies forwarding muxes, runs the ALU, computes the branch target and destination register, then registers everything into the EX/MEM pipeline register feeding the memory stage.

Parameters:
- DW, 32, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE  in  1 each  control bits from decode
- ALUControlE  in  3  ALU operation
- RD1E, RD2E  in  DW  register operands
- SignImmE, PCPlus4E  in  DW  immediate, PC+4
- RsE, RtE, RdE  in  RW  register indices
- ForwardAE, ForwardBE  in  2  from hazard unit: 00 = RDxE, 01 = ResultW, 10 = ALUOutM, 11 = RDxE
- ResultW  in  DW  writeback result
- RegWriteM, MemtoRegM, MemWriteM, BranchM  out  1 each  registered control bits
- ZeroM  out  1  registered ALU zero flag
- ALUOutM, WriteDataM, PCBranchM  out  DW  registered ALU result, store data, branch target
- WriteRegM  out  RW  registered destination index
- WriteRegE  out  RW  combinational destination index, for the hazard unit
- BusyE  out  1  combinational; E stage occupied by a multi-cycle op (constant 0 without MUL_EN)

Behaviour:
- SrcAE = ForwardAE mux.
- WriteDataE = ForwardBE mux.
- SrcBE = ALUSrcE ? SignImmE : WriteDataE.
- ALU encoding:
  - 010 add; 110 sub; 000 and; 001 or
  - 111 slt: signed compare, result is 1 or 0
  - 011 mul (MUL_EN only); otherwise treated as 000
  - 100, 101 → 0
- Add/sub wrap modulo 2^DW; no overflow trap.
- ZeroE = (ALU result == 0).
- WriteRegE = RegDstE ? RdE : RtE.
- PCBranchE = PCPlus4E + (SignImmE << 2), truncated to DW.
- EX/MEM register:
  - Updates every posedge; latency is one cycle E→M.
  - Forwarding path ALUOutM → SrcA/B is combinational within the same cycle.
- Reset: every M output is 0 and BusyE = 0 on the first edge with rst=1. Reset overrides all other activity, including a mid-multiply.
- No stall/flush inputs. A bubble is inserted in M only by the multiply sequence.

Optional Feature:
- Macro: MUL_EN.
- Defined: ALUControlE = 011 is an iterative shift-add multiply giving the low DW bits of the unsigned product (equal to the signed low word).
  - FSM: IDLE → RUN → DONE → IDLE.
  - IDLE with ALUControlE = 011: latch the forwarded SrcAE/SrcBE, clear the accumulator, cnt = 0, BusyE = 1, go RUN.
  - RUN: one bit per cycle, cnt++; BusyE = 1; after the cycle with cnt = DW-1, go DONE.
  - DONE: BusyE = 0; M latches ALUOutM = product along with the instruction's control bits; return to IDLE unconditionally, so there is no re-trigger while the same instruction is present.
  - Total E occupancy is DW+2 cycles.
  - While BusyE = 1, all M outputs are loaded with 0 (bubble).
  - The hazard unit must stall F/D/E on BusyE; operands are already captured, so later forwarding changes are ignored.
  - Reset mid-RUN returns to IDLE.
- Undefined: code 011 behaves as 000; BusyE is tied to 0; no FSM or counter is synthesised.

Decomposition:
- mips_pkg holds:
  - ALU opcode localparams: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MUL
  - Forward-select constants: FWD_RF, FWD_WB, FWD_MEM
  - mul_state_t enum (IDLE/RUN/DONE)
- Sub-module alu: combinational, ALUControl/SrcA/SrcB → ALUResult, Zero.
- The multiplier FSM stays inside execute_cycle under `ifdef`.

Test Plan:
1. rst=1 for 2 cycles with random inputs → all M outputs 0, BusyE = 0.
2. ALUControlE=010, ALUSrcE=0, RD1E=5, RD2E=0xFFFFFFFF, Forward=00 → next cycle ALUOutM = 4, ZeroM = 0. Then 110 with RD1E=RD2E=7 → ALUOutM = 0, ZeroM = 1.
3. slt with RD1E=0xFFFFFFFE, RD2E=1 → ALUOutM = 1. ALUSrcE=1, SignImmE=0xFFFFFFFC, PCPlus4E=0x100 → PCBranchM = 0xF0.
4. ForwardAE=10 with ALUOutM = 0x10 held from the previous op, ForwardBE=01 with ResultW=3, add → ALUOutM = 0x13, WriteDataM = 3. RegDstE=1, RdE=9, RtE=4 → WriteRegM = 9.
5. MUL_EN: mul 0xFFFFFFFF × 3 → BusyE high 33 cycles, M outputs 0 during that time, then ALUOutM = 0xFFFFFFFD with RegWriteM = 1 for one op. Without MUL_EN, the same stimulus gives ALUOutM = 3 and BusyE stays 0.
6. MUL_EN: assert rst at RUN cnt=10 → next edge BusyE = 0, outputs 0; a new add then completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS execute stage: ALU opcodes, forward selects, multiplier states.
// Latency: not applicable (declarations only). Backpressure: not applicable.
package mips_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mul_state_t;

endpackage

// File: rtl/execute_cycle_alu.sv
// Combinational ALU for the execute stage. Code 011 is treated as AND here.
// Latency: zero cycles. Backpressure: none.
module alu
    import mips_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    alu_control,
    input  logic [DW-1:0] src_a,
    input  logic [DW-1:0] src_b,
    output logic [DW-1:0] alu_result,
    output logic          zero
);

    always_comb begin
        alu_result = '0;
        case (alu_control)
            ALU_ADD:          alu_result = src_a + src_b;
            ALU_SUB:          alu_result = src_a - src_b;
            ALU_AND, ALU_MUL: alu_result = src_a & src_b;
            ALU_OR:           alu_result = src_a | src_b;
            ALU_SLT:          alu_result = {{(DW-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default:          alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

endmodule

// File: rtl/execute_cycle.sv
// MIPS execute stage: forwarding muxes, ALU, branch target, EX/MEM register. Optional MUL_EN adds an iterative multiply.
// Latency: one cycle E->M; a multiply occupies E for DW+2 cycles. Backpressure: BusyE asks the hazard unit to stall F/D/E.
module execute_cycle
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          RegWriteE,
    input  logic          MemtoRegE,
    input  logic          MemWriteE,
    input  logic          BranchE,
    input  logic          ALUSrcE,
    input  logic          RegDstE,
    input  logic [2:0]    ALUControlE,
    input  logic [DW-1:0] RD1E,
    input  logic [DW-1:0] RD2E,
    input  logic [DW-1:0] SignImmE,
    input  logic [DW-1:0] PCPlus4E,
    input  logic [RW-1:0] RsE,
    input  logic [RW-1:0] RtE,
    input  logic [RW-1:0] RdE,
    input  logic [1:0]    ForwardAE,
    input  logic [1:0]    ForwardBE,
    input  logic [DW-1:0] ResultW,
    output logic          RegWriteM,
    output logic          MemtoRegM,
    output logic          MemWriteM,
    output logic          BranchM,
    output logic          ZeroM,
    output logic [DW-1:0] ALUOutM,
    output logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] PCBranchM,
    output logic [RW-1:0] WriteRegM,
    output logic [RW-1:0] WriteRegE,
    output logic          BusyE
);

    logic [DW-1:0] SrcAE, SrcBE, WriteDataE, PCBranchE;
    logic [DW-1:0] alu_result, ex_result;
    logic          alu_zero, ex_zero;

    // RsE is consumed by the hazard unit, not here.
    logic unused_rs;
    assign unused_rs = ^RsE;

    always_comb begin
        case (ForwardAE)
            FWD_WB:  SrcAE = ResultW;
            FWD_MEM: SrcAE = ALUOutM;
            default: SrcAE = RD1E;
        endcase
        case (ForwardBE)
            FWD_WB:  WriteDataE = ResultW;
            FWD_MEM: WriteDataE = ALUOutM;
            default: WriteDataE = RD2E;
        endcase
    end

    assign SrcBE     = ALUSrcE ? SignImmE : WriteDataE;
    assign WriteRegE = RegDstE ? RdE : RtE;
    assign PCBranchE = PCPlus4E + (SignImmE << 2);

    alu #(.DW(DW)) u_alu (
        .alu_control (ALUControlE),
        .src_a       (SrcAE),
        .src_b       (SrcBE),
        .alu_result  (alu_result),
        .zero        (alu_zero)
    );

`ifdef MUL_EN
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    mul_state_t    state, state_nxt;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mul_a, mul_b, acc;
    logic          busy_raw, mul_start;

    assign mul_start = (state == IDLE) && (ALUControlE == ALU_MUL);

    always_comb begin
        state_nxt = state;
        busy_raw  = 1'b0;
        case (state)
            IDLE: begin
                if (mul_start) begin
                    busy_raw  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_raw = 1'b1;
                if (cnt == CW'(DW-1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured at start so forwarding changes during the stall are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mul_a <= '0;
            mul_b <= '0;
            acc   <= '0;
        end else begin
            state <= state_nxt;
            if (mul_start) begin
                mul_a <= SrcAE;
                mul_b <= SrcBE;
                acc   <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                if (mul_b[0])
                    acc <= acc + mul_a;
                mul_a <= mul_a << 1;
                mul_b <= mul_b >> 1;
                cnt   <= cnt + CW'(1);
            end
        end
    end

    assign BusyE     = busy_raw & ~rst;
    assign ex_result = (state == DONE) ? acc : alu_result;
    assign ex_zero   = (state == DONE) ? (acc == '0) : alu_zero;
`else
    assign BusyE     = 1'b0;
    assign ex_result = alu_result;
    assign ex_zero   = alu_zero;
`endif

    // While a multiply is in flight the M stage receives a bubble.
    always_ff @(posedge clk) begin
        if (rst || BusyE) begin
            RegWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            BranchM    <= 1'b0;
            ZeroM      <= 1'b0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            PCBranchM  <= '0;
            WriteRegM  <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemtoRegM  <= MemtoRegE;
            MemWriteM  <= MemWriteE;
            BranchM    <= BranchE;
            ZeroM      <= ex_zero;
            ALUOutM    <= ex_result;
            WriteDataM <= WriteDataE;
            PCBranchM  <= PCBranchE;
            WriteRegM  <= WriteRegE;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed self-checking bench for execute_cycle; expectations adapt to whether MUL_EN is defined.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteE, MemtoRegE, MemWriteE, BranchE, ALUSrcE, RegDstE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, SignImmE, PCPlus4E, ResultW;
    logic [4:0]  RsE, RtE, RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM, BusyE;
    logic [31:0] ALUOutM, WriteDataM, PCBranchM;
    logic [4:0]  WriteRegM, WriteRegE;

    int checks = 0;
    int passed = 0;

    execute_cycle #(.DW(32), .RW(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
        .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E),
        .SignImmE(SignImmE), .PCPlus4E(PCPlus4E),
        .RsE(RsE), .RtE(RtE), .RdE(RdE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .BranchM(BranchM), .ZeroM(ZeroM), .ALUOutM(ALUOutM),
        .WriteDataM(WriteDataM), .PCBranchM(PCBranchM), .WriteRegM(WriteRegM),
        .WriteRegE(WriteRegE), .BusyE(BusyE)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0; BranchE = 0;
        ALUSrcE = 0; RegDstE = 0; ALUControlE = 3'b010;
        RD1E = 0; RD2E = 0; SignImmE = 0; PCPlus4E = 0; ResultW = 0;
        RsE = 0; RtE = 0; RdE = 0; ForwardAE = 2'b00; ForwardBE = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            RegWriteE = 1; MemtoRegE = 1; MemWriteE = 1; BranchE = 1;
            ALUSrcE = 1'($urandom); RegDstE = 1'($urandom);
            ALUControlE = 3'($urandom); RD1E = $urandom; RD2E = $urandom;
            SignImmE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
            RsE = 5'($urandom); RtE = 5'($urandom); RdE = 5'($urandom);
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            step();
            checks++;
            if ({RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM, BusyE} !== 6'b0 ||
                ALUOutM !== 0 || WriteDataM !== 0 || PCBranchM !== 0 || WriteRegM !== 0)
                $display("FAIL reset_outputs cycle %0d: got ctl=%b alu=%h wd=%h pcb=%h wr=%h busy=%b, want all 0",
                         i, {RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM}, ALUOutM, WriteDataM,
                         PCBranchM, WriteRegM, BusyE);
            else passed++;
        end
        rst = 0;
        clear_inputs();
    endtask

    task automatic test_add_sub();
        ALUControlE = 3'b010; RD1E = 32'd5; RD2E = 32'hFFFF_FFFF; RegWriteE = 1;
        step();
        checks++;
        if (ALUOutM !== 32'd4 || ZeroM !== 1'b0 || RegWriteM !== 1'b1)
            $display("FAIL add_wrap: got alu=%h zero=%b rw=%b, want 00000004 0 1", ALUOutM, ZeroM, RegWriteM);
        else passed++;
        ALUControlE = 3'b110; RD1E = 32'd7; RD2E = 32'd7; RegWriteE = 0;
        step();
        checks++;
        if (ALUOutM !== 32'd0 || ZeroM !== 1'b1 || RegWriteM !== 1'b0)
            $display("FAIL sub_zero: got alu=%h zero=%b rw=%b, want 00000000 1 0", ALUOutM, ZeroM, RegWriteM);
        else passed++;
        ALUControlE = 3'b100; RD1E = 32'h1234; RD2E = 32'h5678;
        step();
        checks++;
        if (ALUOutM !== 32'd0 || ZeroM !== 1'b1)
            $display("FAIL op100_zero: got alu=%h zero=%b, want 00000000 1", ALUOutM, ZeroM);
        else passed++;
    endtask

    task automatic test_slt_branch();
        ALUControlE = 3'b111; RD1E = 32'hFFFF_FFFE; RD2E = 32'd1;
        step();
        checks++;
        if (ALUOutM !== 32'd1) $display("FAIL slt_signed: got %h, want 00000001", ALUOutM);
        else passed++;
        ALUControlE = 3'b010; ALUSrcE = 1; RD1E = 32'h10; RD2E = 32'hDEAD;
        SignImmE = 32'hFFFF_FFFC; PCPlus4E = 32'h100; BranchE = 1;
        step();
        checks++;
        if (PCBranchM !== 32'hF0 || ALUOutM !== 32'hC || BranchM !== 1'b1 || WriteDataM !== 32'hDEAD)
            $display("FAIL branch_target: got pcb=%h alu=%h br=%b wd=%h, want 000000f0 0000000c 1 0000dead",
                     PCBranchM, ALUOutM, BranchM, WriteDataM);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_forwarding();
        ALUControlE = 3'b010; RD1E = 32'h8; RD2E = 32'h8;
        step();
        checks++;
        if (ALUOutM !== 32'h10) $display("FAIL fwd_setup: got %h, want 00000010", ALUOutM);
        else passed++;
        ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd3;
        RD1E = 32'hAAAA_0000; RD2E = 32'h5555_0000;
        RegDstE = 1; RdE = 5'd9; RtE = 5'd4; MemWriteE = 1;
        #1;
        checks++;
        if (WriteRegE !== 5'd9) $display("FAIL write_reg_e: got %0d, want 9", WriteRegE);
        else passed++;
        step();
        checks++;
        if (ALUOutM !== 32'h13 || WriteDataM !== 32'd3 || WriteRegM !== 5'd9 || MemWriteM !== 1'b1)
            $display("FAIL fwd_mem_wb: got alu=%h wd=%h wr=%0d mw=%b, want 00000013 00000003 9 1",
                     ALUOutM, WriteDataM, WriteRegM, MemWriteM);
        else passed++;
        ForwardAE = 2'b11; ForwardBE = 2'b11; RD1E = 32'd1; RD2E = 32'd2; RegDstE = 0;
        step();
        checks++;
        if (ALUOutM !== 32'd3 || WriteRegM !== 5'd4)
            $display("FAIL fwd_sel11: got alu=%h wr=%0d, want 00000003 4", ALUOutM, WriteRegM);
        else passed++;
        clear_inputs();
    endtask

    task automatic test_mul();
        int bad_busy = 0;
        int bad_bubble = 0;
        ALUControlE = 3'b011; RD1E = 32'hFFFF_FFFF; RD2E = 32'd3; RegWriteE = 1; RtE = 5'd6;
`ifdef MUL_EN
        for (int i = 0; i < 33; i++) begin
            if (BusyE !== 1'b1) bad_busy++;
            step();
            if (ALUOutM !== 0 || RegWriteM !== 0 || WriteRegM !== 0) bad_bubble++;
            // Forwarding changes after capture must not disturb the product.
            RD1E = 32'h1111_1111; RD2E = 32'h2222_2222;
        end
        checks++;
        if (bad_busy != 0) $display("FAIL mul_busy: %0d of 33 cycles had BusyE low, want 0", bad_busy);
        else passed++;
        checks++;
        if (bad_bubble != 0) $display("FAIL mul_bubble: %0d of 33 cycles had nonzero M outputs, want 0", bad_bubble);
        else passed++;
        checks++;
        if (BusyE !== 1'b0) $display("FAIL mul_done_busy: got %b, want 0", BusyE);
        else passed++;
        step();
        checks++;
        if (ALUOutM !== 32'hFFFF_FFFD || RegWriteM !== 1'b1 || WriteRegM !== 5'd6 || ZeroM !== 1'b0)
            $display("FAIL mul_result: got alu=%h rw=%b wr=%0d z=%b, want fffffffd 1 6 0",
                     ALUOutM, RegWriteM, WriteRegM, ZeroM);
        else passed++;
        ALUControlE = 3'b010; RD1E = 32'd1; RD2E = 32'd1; RegWriteE = 0;
        #1;
        checks++;
        if (BusyE !== 1'b0) $display("FAIL mul_no_retrigger: got %b, want 0", BusyE);
        else passed++;
        step();
        checks++;
        if (ALUOutM !== 32'd2 || RegWriteM !== 1'b0)
            $display("FAIL after_mul_add: got alu=%h rw=%b, want 00000002 0", ALUOutM, RegWriteM);
        else passed++;
`else
        #1;
        checks++;
        if (BusyE !== 1'b0) $display("FAIL mul_busy_off: got %b, want 0", BusyE);
        else passed++;
        step();
        checks++;
        if (ALUOutM !== 32'd3 || RegWriteM !== 1'b1 || BusyE !== 1'b0)
            $display("FAIL mul_as_and: got alu=%h rw=%b busy=%b, want 00000003 1 0", ALUOutM, RegWriteM, BusyE);
        else passed++;
`endif
        clear_inputs();
    endtask

    task automatic test_reset_mid_mul();
        ALUControlE = 3'b011; RD1E = 32'd7; RD2E = 32'd9; RegWriteE = 1;
        for (int i = 0; i < 11; i++) step();
`ifdef MUL_EN
        checks++;
        if (BusyE !== 1'b1) $display("FAIL mid_mul_busy: got %b, want 1", BusyE);
        else passed++;
`endif
        rst = 1;
        step();
        checks++;
        if (BusyE !== 1'b0 || ALUOutM !== 0 || RegWriteM !== 0 || WriteRegM !== 0)
            $display("FAIL reset_mid_mul: got busy=%b alu=%h rw=%b wr=%0d, want 0 0 0 0",
                     BusyE, ALUOutM, RegWriteM, WriteRegM);
        else passed++;
        rst = 0;
        ALUControlE = 3'b010; RD1E = 32'd2; RD2E = 32'd3;
        #1;
        checks++;
        if (BusyE !== 1'b0) $display("FAIL post_reset_busy: got %b, want 0", BusyE);
        else passed++;
        step();
        checks++;
        if (ALUOutM !== 32'd5 || RegWriteM !== 1'b1)
            $display("FAIL post_reset_add: got alu=%h rw=%b, want 00000005 1", ALUOutM, RegWriteM);
        else passed++;
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        #2;
        test_reset();
        test_add_sub();
        test_slt_branch();
        test_forwarding();
        test_mul();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
